// File: rtl/ext_bus_master.sv
// ext_bus_master: one-byte initiator for the 8-bit external parallel bus.
// Generates timed setup/strobe/hold cycles and a turnaround gap after reads.
module ext_bus_master #(
  parameter int ADDR_WIDTH    = 21,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int TURN_CYCLES   = 4
) (
  input  logic                  clk_usb,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  done,
  output logic [7:0]            rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic [7:0]            data_in,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic                  cen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } state_e;

  // Counters hold "cycles left minus one" so zero marks the last cycle.
  localparam logic [7:0] SET_N = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STB_N = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HLD_N = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TRN_N = 8'(TURN_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              dout_q, dout_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    last;

  assign last = (cnt_q == 8'd0);

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = SET_N;
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          dout_d  = cmd_wdata;
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_STROBE;
          cnt_d   = STB_N;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (last) begin
          state_d = S_HOLD;
          cnt_d   = HLD_N;
          // Sample on the edge where !RD rises.
          if (!wr_q) begin
            rdata_d = data_in;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = wr_q ? S_IDLE : S_TURN;
          cnt_d   = TRN_N;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_TURN: begin
        if (last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cen     = 1'b1;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    data_oe = 1'b0;
    unique case (state_q)
      S_SETUP, S_HOLD: begin
        cen     = 1'b0;
        data_oe = wr_q;
      end
      S_STROBE: begin
        cen     = 1'b0;
        data_oe = wr_q;
        rd_en   = wr_q;
        wr_en   = ~wr_q;
      end
      default: begin
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign addr      = addr_q;
  assign data_out  = dout_q;

endmodule

// File: doc/ext_bus_master.md
# ext_bus_master

Single-clock initiator for the SAM3U-style 8-bit external parallel bus. This bus has a 21-bit address, active-low !RD/!WR/!CE strobes and a shared data bus. The block turns one-byte read/write commands from a local requester into correctly timed bus cycles with configurable setup, strobe and hold phases. It enforces a bus turnaround after reads, because the responder keeps driving data for up to 3 clocks after !RD rises. It is used as the on-chip driver of the target register bus, for loopback and self-test builds and for bench stimulus. The tristate buffer sits at the top level; this block exposes separate out/oe/in data signals.

## Interface
Parameters:
- ADDR_WIDTH, 21: bus address width.
- SETUP_CYCLES, 1: cycles of address/!CE (and write data) valid before the strobe falls. Minimum 1.
- STROBE_CYCLES, 2: cycles the !RD/!WR strobe is held low. Minimum 1.
- HOLD_CYCLES, 1: cycles address/data/!CE are held after the strobe rises. Minimum 1.
- TURN_CYCLES, 4: idle cycles after a read before the next bus cycle may begin. Minimum 4.

Ports (one clock; reset is synchronous and active-high):
- clk_usb  in  1  bus clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  8  write byte.
- done  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; valid while done=1 after a read, held until the next read completes.
- busy  out  1  ~cmd_ready.
- addr  out  ADDR_WIDTH  bus address.
- data_out  out  8  bus write data.
- data_oe  out  1  1 = master drives the data bus.
- data_in  in  8  bus data from the pad.
- rd_en  out  1  !RD, active low.
- wr_en  out  1  !WR, active low.
- cen  out  1  !CE, active low.

## Operation
- Reset state: state=IDLE, rd_en=wr_en=cen=1, data_oe=0, addr=0, data_out=0, rsp_rdata=0, done=0, cmd_ready=1.
- A command is accepted on an edge where cmd_valid & cmd_ready.
  - On acceptance, cmd_write, cmd_addr and cmd_wdata are registered.
  - Command inputs are ignored at all other times.
- States and transitions (a phase counter is reloaded on each state entry):
  - IDLE -> SETUP on acceptance.
  - SETUP (SETUP_CYCLES cycles) -> STROBE.
  - STROBE (STROBE_CYCLES cycles) -> HOLD.
  - HOLD (HOLD_CYCLES cycles) -> TURN after a read; -> IDLE after a write.
  - TURN (TURN_CYCLES cycles) -> IDLE.
- Outputs by state:
  - SETUP, STROBE and HOLD: cen=0; addr = latched address.
  - Writes only: data_out = latched byte and data_oe=1 for all of SETUP, STROBE and HOLD.
  - STROBE only: rd_en=0 for a read, or wr_en=0 for a write.
  - TURN: cen=1, strobes high, data_oe=0. addr holds its last value, with no glitch.
- Read capture: rsp_rdata <= data_in on the edge that leaves STROBE, i.e. the edge where rd_en rises.
- data_oe is never 1 on a read. data_oe is never 1 while rd_en=0 or during TURN.
- The address is passed through unmodified; the block does no range checking.
- Reset mid-operation:
  - The next edge forces the reset state.
  - done is not pulsed and the in-flight command is dropped.
  - rsp_rdata clears to 0.

## Timing
- Acceptance edge = cycle 0. SETUP occupies cycles 1..S. STROBE occupies S+1..S+P. HOLD occupies S+P+1..S+P+H.
- done pulses in cycle S+P+H+1.
- Write: cmd_ready=1 in the done cycle, so back-to-back writes give a period of S+P+H+1 cycles (5 with defaults).
- Read: the TURN state begins in the done cycle. cmd_ready returns at cycle S+P+H+T+1 (9 with defaults).
- wr_en rises exactly one cycle before data_oe falls. The responder latches on the wr_en rising edge while the data is still driven.
- cmd_valid held high across busy produces exactly one acceptance per cmd_ready window.

## Test plan
- Write 0xA5 to addr 0x010 (defaults, responder model attached):
  - wr_en low for exactly cycles 2–3.
  - data_out=0xA5 with data_oe=1 over cycles 1–4.
  - Responder byte 0x10 = 0xA5; done at cycle 5.
- Read addr 0x020, with the responder holding 0x3C there:
  - rd_en low for cycles 2–3; data_oe=0 throughout.
  - done at cycle 5 with rsp_rdata=0x3C.
  - cmd_ready low until cycle 9.
- Read 0x001 then write 0x5A to 0x001, cmd_valid held continuously:
  - The write's SETUP does not start before cycle 10.
  - data_oe and the responder drive never overlap.
  - The responder ends with 0x5A at 0x001.
- Two back-to-back writes (0x11 to 0x000, then 0x22 to 0x001):
  - Accepted at cycles 0 and 5.
  - !CE low for cycles 1–4 and 6–9, high in cycles 5 and 10.
- reset asserted in the first STROBE cycle of a read:
  - Next cycle: rd_en=cen=1, data_oe=0, rsp_rdata=0, cmd_ready=1.
  - done never pulses for the dropped read.
- SETUP_CYCLES=2, STROBE_CYCLES=4, HOLD_CYCLES=2, write 0xFF to 0x0FF:
  - wr_en low for cycles 3–6.
  - done at cycle 9.
